// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file and trap sequencer.
// Holds CSR addresses, access op encodings, interrupt cause codes, status/enable
// bit positions, the trap FSM state type and the mtvec mode legaliser.
package csr_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MSIE_BIT     = 3;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REDIRECT   = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } trap_state_e;

  // Only direct (0) and vectored (1) are supported; bit 1 of the mode field
  // is reserved and always stored as 0.
  function automatic logic [1:0] mtvec_mode_fix(input logic [1:0] mode);
    return {1'b0, mode[0]};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter with increment enable and independent
// 32-bit write ports for each half.
//   clk, rst_n       clock, async active-low reset
//   inc              count one event this cycle
//   wr_lo / wr_hi    software write of the low / high half
//   wdata_lo/hi      write data for each half
//   count            current value
// A software write to either half suppresses the increment for that cycle, so
// the written half takes the new value and the other half holds.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count
);

  logic [63:0] count_inc;
  assign count_inc = count + 64'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata_lo;
      if (wr_hi) count[63:32] <= wdata_hi;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/csr_mtrap_unit.sv
// csr_mtrap_unit: machine-mode CSR file with interrupt entry / mret sequencing.
//   clk_in, rst_n_in            clock, async active-low reset
//   rdy_in                      global stall (0 freezes all state)
//   csr_req_in/addr/op/wen/wdata  CSR access from execute
//   csr_rdata_out               pre-write CSR value (0 if no access or illegal)
//   csr_illegal_out             unimplemented CSR or write to read-only CSR
//   csr_ready_out               CSR accesses accepted only while idle
//   retire_in, epc_in, mret_in  retirement info from the pipeline
//   irq_*_in                    level interrupt lines
//   redirect_valid/pc_out       one-cycle fetch redirect
//   flush_done_in               pipeline drained after a redirect
//
// state         | meaning
// ST_IDLE       | accepting CSR accesses, watching for mret / interrupts
// ST_REDIRECT   | redirect pulse on fetch for one cycle
// ST_FLUSH_WAIT | waiting for the pipeline to drain
module csr_mtrap_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     HART_ID     = 0,
  parameter logic [31:0]     MISA_VALUE  = 32'h4000_0100,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  input  logic            csr_req_in,
  input  logic [11:0]     csr_addr_in,
  input  logic [1:0]      csr_op_in,
  input  logic            csr_wen_in,
  input  logic [XLEN-1:0] csr_wdata_in,
  output logic [XLEN-1:0] csr_rdata_out,
  output logic            csr_illegal_out,
  output logic            csr_ready_out,
  input  logic            retire_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic            mret_in,
  input  logic            irq_mtip_in,
  input  logic            irq_msip_in,
  input  logic            irq_meip_in,
  output logic            redirect_valid_out,
  output logic [XLEN-1:0] redirect_pc_out,
  input  logic            flush_done_in
);

  localparam logic [11:0] CNT_HI_CYCLE   = (XLEN == 64) ? CSR_MCYCLE   : CSR_MCYCLEH;
  localparam logic [11:0] CNT_HI_INSTRET = (XLEN == 64) ? CSR_MINSTRET : CSR_MINSTRETH;
  localparam logic        HAS_HI         = (XLEN == 32);

  trap_state_e     state;
  logic            mstatus_mie, mstatus_mpie;
  logic [2:0]      mie_en;  // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0]     mcycle, minstret;

  logic            csr_active, known, read_only, write_attempt, csr_write;
  logic [XLEN-1:0] old_val, new_val, trap_vec, mtvec_base;
  logic [63:0]     new_val64;
  logic [31:0]     cnt_wdata_hi;
  logic [2:0]      pending;  // {MEI, MTI, MSI}
  logic [3:0]      irq_cause;
  logic            mret_go, irq_go;

  assign csr_ready_out = (state == ST_IDLE);
  // mret owns the cycle: a CSR access presented alongside it is dropped.
  assign csr_active    = csr_req_in && csr_ready_out && !mret_in;
  assign write_attempt = (csr_op_in == OP_RW) ||
                         (((csr_op_in == OP_RS) || (csr_op_in == OP_RC)) && csr_wen_in);

  always_comb begin
    known     = 1'b1;
    read_only = 1'b0;
    old_val   = '0;
    case (csr_addr_in)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
      CSR_MHARTID:   begin read_only = 1'b1; old_val = XLEN'(HART_ID); end
      CSR_MSTATUS:   old_val = XLEN'({2'b11, 3'b000, mstatus_mpie, 3'b000, mstatus_mie, 3'b000});
      CSR_MISA:      old_val = XLEN'(MISA_VALUE);
      CSR_MIE:       old_val = XLEN'({mie_en[2], 3'b000, mie_en[1], 3'b000, mie_en[0], 3'b000});
      CSR_MTVEC:     old_val = mtvec;
      CSR_MSCRATCH:  old_val = mscratch;
      CSR_MEPC:      old_val = mepc;
      CSR_MCAUSE:    old_val = mcause;
      CSR_MTVAL:     old_val = mtval;
      CSR_MIP: begin
        read_only = 1'b1;
        old_val   = XLEN'({irq_meip_in, 3'b000, irq_mtip_in, 3'b000, irq_msip_in, 3'b000});
      end
      CSR_MCYCLE:    old_val = XLEN'(mcycle);
      CSR_MINSTRET:  old_val = XLEN'(minstret);
      CSR_CYCLE:     begin read_only = 1'b1; old_val = XLEN'(mcycle); end
      CSR_INSTRET:   begin read_only = 1'b1; old_val = XLEN'(minstret); end
      CSR_MCYCLEH:   begin known = HAS_HI; old_val = HAS_HI ? XLEN'(mcycle[63:32]) : '0; end
      CSR_MINSTRETH: begin known = HAS_HI; old_val = HAS_HI ? XLEN'(minstret[63:32]) : '0; end
      CSR_CYCLEH: begin
        known = HAS_HI; read_only = 1'b1;
        old_val = HAS_HI ? XLEN'(mcycle[63:32]) : '0;
      end
      CSR_INSTRETH: begin
        known = HAS_HI; read_only = 1'b1;
        old_val = HAS_HI ? XLEN'(minstret[63:32]) : '0;
      end
      default:       known = 1'b0;
    endcase
  end

  assign csr_illegal_out = csr_active && (!known || (read_only && write_attempt));
  assign csr_rdata_out   = (csr_active && !csr_illegal_out) ? old_val : '0;
  assign csr_write       = csr_active && !csr_illegal_out && write_attempt && rdy_in;

  always_comb begin
    case (csr_op_in)
      OP_RW:   new_val = csr_wdata_in;
      OP_RS:   new_val = old_val | csr_wdata_in;
      default: new_val = old_val & ~csr_wdata_in;
    endcase
  end

  // XLEN=64 writes both halves from one access; XLEN=32 uses the separate high CSR.
  assign new_val64    = 64'(new_val);
  assign cnt_wdata_hi = (XLEN == 64) ? new_val64[63:32] : new_val64[31:0];

  csr_counter64 u_mcycle (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .inc      (rdy_in),
    .wr_lo    (csr_write && (csr_addr_in == CSR_MCYCLE)),
    .wr_hi    (csr_write && (csr_addr_in == CNT_HI_CYCLE)),
    .wdata_lo (new_val64[31:0]),
    .wdata_hi (cnt_wdata_hi),
    .count    (mcycle)
  );

  csr_counter64 u_minstret (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .inc      (rdy_in && retire_in),
    .wr_lo    (csr_write && (csr_addr_in == CSR_MINSTRET)),
    .wr_hi    (csr_write && (csr_addr_in == CNT_HI_INSTRET)),
    .wdata_lo (new_val64[31:0]),
    .wdata_hi (cnt_wdata_hi),
    .count    (minstret)
  );

  assign pending   = {irq_meip_in && mie_en[2], irq_mtip_in && mie_en[1], irq_msip_in && mie_en[0]};
  assign irq_cause = pending[2] ? CAUSE_MEI : (pending[0] ? CAUSE_MSI : CAUSE_MTI);
  assign mret_go   = rdy_in && csr_ready_out && mret_in;
  assign irq_go    = rdy_in && csr_ready_out && mstatus_mie && (pending != 3'b000) &&
                     !csr_req_in && !mret_in;

  assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};
  assign trap_vec   = (mtvec[1:0] == 2'b01) ? mtvec_base + XLEN'({irq_cause, 2'b00}) : mtvec_base;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_en       <= '0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else if (rdy_in) begin
      if (mret_go) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (irq_go) begin
        mepc         <= epc_in & ~XLEN'(3);
        mcause       <= {1'b1, (XLEN-1)'(irq_cause)};
        mtval        <= '0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (csr_write) begin
        case (csr_addr_in)
          CSR_MSTATUS: begin
            mstatus_mie  <= new_val[MSTATUS_MIE_BIT];
            mstatus_mpie <= new_val[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      mie_en <= {new_val[MIE_MEIE_BIT], new_val[MIE_MTIE_BIT], new_val[MIE_MSIE_BIT]};
          CSR_MTVEC:    mtvec <= {new_val[XLEN-1:2], mtvec_mode_fix(new_val[1:0])};
          CSR_MSCRATCH: mscratch <= new_val;
          CSR_MEPC:     mepc <= new_val & ~XLEN'(3);
          CSR_MCAUSE:   mcause <= new_val;
          CSR_MTVAL:    mtval <= new_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= ST_IDLE;
      redirect_valid_out <= 1'b0;
      redirect_pc_out    <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (mret_go || irq_go) begin
            state              <= ST_REDIRECT;
            redirect_valid_out <= 1'b1;
            redirect_pc_out    <= mret_go ? mepc : trap_vec;
          end
        end
        ST_REDIRECT: begin
          state              <= ST_FLUSH_WAIT;
          redirect_valid_out <= 1'b0;
          redirect_pc_out    <= '0;
        end
        ST_FLUSH_WAIT: if (flush_done_in) state <= ST_IDLE;
        default: begin
          state              <= ST_IDLE;
          redirect_valid_out <= 1'b0;
          redirect_pc_out    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_mtrap_unit.sv
module tb_csr_mtrap_unit;
  localparam int HART = 5;
  localparam logic [31:0] MISA = 32'h4000_0100;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, csr_req_in, csr_wen_in;
  logic [11:0] csr_addr_in;
  logic [1:0]  csr_op_in;
  logic [31:0] csr_wdata_in, csr_rdata_out, epc_in, redirect_pc_out;
  logic        csr_illegal_out, csr_ready_out, retire_in, mret_in;
  logic        irq_mtip_in, irq_msip_in, irq_meip_in, redirect_valid_out, flush_done_in;

  always #5 clk_in = ~clk_in;

  csr_mtrap_unit #(.XLEN(32), .HART_ID(HART), .MISA_VALUE(MISA), .MTVEC_RESET(32'h0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .csr_req_in(csr_req_in),
    .csr_addr_in(csr_addr_in), .csr_op_in(csr_op_in), .csr_wen_in(csr_wen_in),
    .csr_wdata_in(csr_wdata_in), .csr_rdata_out(csr_rdata_out),
    .csr_illegal_out(csr_illegal_out), .csr_ready_out(csr_ready_out),
    .retire_in(retire_in), .epc_in(epc_in), .mret_in(mret_in),
    .irq_mtip_in(irq_mtip_in), .irq_msip_in(irq_msip_in), .irq_meip_in(irq_meip_in),
    .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
    .flush_done_in(flush_done_in)
  );

  int total = 0;
  int bad = 0;

  // Reference model: architectural state as plain values.
  bit          m_mie, m_mpie, m_rv;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  bit   [63:0] m_cycle, m_instret;
  int          m_phase;  // 0 idle, 1 redirecting, 2 waiting for flush
  logic [31:0] last_rd;
  logic        last_ill;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[24];

  logic [11:0] addrs[26] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304,
                             12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                             12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                             12'h7C0, 12'hF15, 12'h345, 12'hB03, 12'h300};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [11:0] a, output bit kn, output bit ro);
    logic [31:0] v;
    kn = 1; ro = 0; v = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13: ro = 1;
      12'hF14: begin ro = 1; v = HART; end
      12'h300: v = 32'h1800 + (m_mpie ? 32'd128 : 32'd0) + (m_mie ? 32'd8 : 32'd0);
      12'h301: v = MISA;
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin
        ro = 1;
        v = (irq_meip_in ? 32'h800 : 0) | (irq_mtip_in ? 32'h80 : 0) | (irq_msip_in ? 32'h8 : 0);
      end
      12'hB00: v = m_cycle[31:0];
      12'hB02: v = m_instret[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB82: v = m_instret[63:32];
      12'hC00: begin ro = 1; v = m_cycle[31:0]; end
      12'hC02: begin ro = 1; v = m_instret[31:0]; end
      12'hC80: begin ro = 1; v = m_cycle[63:32]; end
      12'hC82: begin ro = 1; v = m_instret[63:32]; end
      default: kn = 0;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    rdy_in = 1; csr_req_in = 0; csr_addr_in = 0; csr_op_in = 2'b10; csr_wen_in = 0;
    csr_wdata_in = 0; retire_in = 0; epc_in = 0; mret_in = 0;
    irq_mtip_in = 0; irq_msip_in = 0; irq_meip_in = 0; flush_done_in = 0;
  endtask

  task automatic do_reset();
    rst_n_in = 0;
    idle_inputs();
    #2;
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0; m_phase = 0; m_rv = 0; m_rpc = 0;
    chk("rst_redir_valid", redirect_valid_out, 0);
    chk("rst_redir_pc", redirect_pc_out, 0);
    chk("rst_rdata", csr_rdata_out, 0);
    chk("rst_illegal", csr_illegal_out, 0);
    chk("rst_ready", csr_ready_out, 1);
    #1 rst_n_in = 1;
  endtask

  // One clock: check combinational outputs, advance the model, check redirect after the edge.
  task automatic tick();
    bit kn, ro, wa, act, ill, nv;
    logic [31:0] oldv, newv, rd_e, npc;
    bit [2:0] pend;
    bit [63:0] nc, ni;
    int cause, nph;
    #2;
    oldv = mread(csr_addr_in, kn, ro);
    wa   = (csr_op_in == 2'b01) || (csr_op_in != 2'b00 && csr_wen_in);
    act  = csr_req_in && m_phase == 0 && !mret_in;
    ill  = act && (!kn || (ro && wa));
    rd_e = (act && !ill) ? oldv : 32'h0;
    last_rd = csr_rdata_out;
    last_ill = csr_illegal_out;
    chk("rdata", csr_rdata_out, rd_e);
    chk("illegal", csr_illegal_out, ill);
    chk("ready", csr_ready_out, m_phase == 0);
    if (rdy_in) begin
      case (csr_op_in)
        2'b01:   newv = csr_wdata_in;
        2'b10:   newv = oldv | csr_wdata_in;
        default: newv = oldv & ~csr_wdata_in;
      endcase
      nc = m_cycle + 1;
      ni = m_instret + (retire_in ? 1 : 0);
      nv = 0; npc = 0; nph = m_phase;
      pend = {irq_meip_in && m_mie_reg[11], irq_msip_in && m_mie_reg[3], irq_mtip_in && m_mie_reg[7]};
      if (m_phase == 0 && mret_in) begin
        nv = 1; npc = m_mepc; nph = 1;
        m_mie = m_mpie; m_mpie = 1;
      end else if (m_phase == 0 && m_mie && pend != 0 && !csr_req_in) begin
        cause = pend[2] ? 11 : (pend[1] ? 3 : 7);
        nv = 1; nph = 1;
        npc = (m_mtvec & ~32'h3) + (m_mtvec[1:0] == 2'b01 ? 32'(4 * cause) : 32'h0);
        m_mepc = epc_in & ~32'h3; m_mcause = 32'h8000_0000 | 32'(cause); m_mtval = 0;
        m_mpie = m_mie; m_mie = 0;
      end else begin
        if (act && !ill && wa) begin
          case (csr_addr_in)
            12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
            12'h304: m_mie_reg = newv & 32'h888;
            12'h305: m_mtvec = newv & ~32'h2;
            12'h340: m_mscratch = newv;
            12'h341: m_mepc = newv & ~32'h3;
            12'h342: m_mcause = newv;
            12'h343: m_mtval = newv;
            12'hB00: nc = {m_cycle[63:32], newv};
            12'hB80: nc = {newv, m_cycle[31:0]};
            12'hB02: ni = {m_instret[63:32], newv};
            12'hB82: ni = {newv, m_instret[31:0]};
            default: ;
          endcase
        end
        if (m_phase == 1) nph = 2;
        else if (m_phase == 2 && flush_done_in) nph = 0;
      end
      m_cycle = nc; m_instret = ni; m_phase = nph; m_rv = nv; m_rpc = npc;
    end
    @(posedge clk_in);
    #1;
    chk("redir_valid", redirect_valid_out, m_rv);
    chk("redir_pc", redirect_pc_out, m_rpc);
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [1:0] op, input logic wen,
                        input logic [31:0] wd);
    csr_req_in = 1; csr_addr_in = a; csr_op_in = op; csr_wen_in = wen; csr_wdata_in = wd;
    tick();
    csr_req_in = 0;
  endtask

  task automatic drain();
    int n = 0;
    flush_done_in = 1;
    while (m_phase != 0 && n < 10) begin tick(); n++; end
    chk("drain_bound", m_phase, 0);
    flush_done_in = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{12'hF14, 2'b10, 1'b0, 32'h0,        32'd5,        1'b0};
    vecs[1]  = '{12'h301, 2'b10, 1'b0, 32'h0,        MISA,         1'b0};
    vecs[2]  = '{12'h305, 2'b01, 1'b1, 32'h103,      32'h0,        1'b0};
    vecs[3]  = '{12'h305, 2'b10, 1'b0, 32'h0,        32'h101,      1'b0};
    vecs[4]  = '{12'h300, 2'b10, 1'b1, 32'h8,        32'h1800,     1'b0};
    vecs[5]  = '{12'h300, 2'b11, 1'b0, 32'h8,        32'h1808,     1'b0};
    vecs[6]  = '{12'h300, 2'b10, 1'b0, 32'h0,        32'h1808,     1'b0};
    vecs[7]  = '{12'h7C0, 2'b01, 1'b1, 32'hFF,       32'h0,        1'b1};
    vecs[8]  = '{12'hF14, 2'b01, 1'b1, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{12'hF14, 2'b10, 1'b0, 32'h0,        32'd5,        1'b0};
    vecs[10] = '{12'h301, 2'b01, 1'b1, 32'h0,        MISA,         1'b0};
    vecs[11] = '{12'h341, 2'b01, 1'b1, 32'h1237,     32'h0,        1'b0};
    vecs[12] = '{12'h341, 2'b10, 1'b0, 32'h0,        32'h1234,     1'b0};
    vecs[13] = '{12'h340, 2'b01, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[14] = '{12'h340, 2'b11, 1'b1, 32'hFFFF0000, 32'hDEADBEEF, 1'b0};
    vecs[15] = '{12'h340, 2'b10, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[16] = '{12'h304, 2'b01, 1'b1, 32'hFFFF,     32'h0,        1'b0};
    vecs[17] = '{12'h304, 2'b10, 1'b0, 32'h0,        32'h888,      1'b0};
    vecs[18] = '{12'h304, 2'b01, 1'b1, 32'h0,        32'h888,      1'b0};
    vecs[19] = '{12'h344, 2'b01, 1'b1, 32'h0,        32'h0,        1'b1};
    vecs[20] = '{12'h344, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[21] = '{12'h305, 2'b01, 1'b1, 32'h202,      32'h101,      1'b0};
    vecs[22] = '{12'h305, 2'b10, 1'b0, 32'h0,        32'h200,      1'b0};
    vecs[23] = '{12'hC00, 2'b01, 1'b1, 32'h0,        32'h0,        1'b1};

    rst_n_in = 0;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      csr_op(vecs[i].addr, vecs[i].op, vecs[i].wen, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), last_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_illegal", i), last_ill, vecs[i].exp_ill);
    end

    // Interrupt entry: MEI beats MTI, vectored target.
    csr_op(12'h304, 2'b01, 1'b1, 32'h880);
    csr_op(12'h305, 2'b01, 1'b1, 32'h201);
    epc_in = 32'h100; irq_mtip_in = 1; irq_meip_in = 1;
    tick();
    chk("irq_valid", redirect_valid_out, 1);
    chk("irq_pc", redirect_pc_out, 32'h22C);
    tick();
    chk("irq_pulse_end", redirect_valid_out, 0);
    tick();
    chk("flush_wait_busy", csr_ready_out, 0);
    irq_mtip_in = 0; irq_meip_in = 0;
    drain();
    csr_op(12'h342, 2'b10, 1'b0, 0); chk("mcause", last_rd, 32'h8000000B);
    csr_op(12'h341, 2'b10, 1'b0, 0); chk("mepc", last_rd, 32'h100);
    csr_op(12'h300, 2'b10, 1'b0, 0); chk("mstatus_trap", last_rd, 32'h1880);

    // mret.
    mret_in = 1; tick(); mret_in = 0;
    chk("mret_pc", redirect_pc_out, 32'h100);
    drain();
    csr_op(12'h300, 2'b10, 1'b0, 0); chk("mstatus_mret", last_rd, 32'h1888);

    // mret and pending interrupt together: mret first, interrupt right after.
    irq_meip_in = 1; mret_in = 1; tick(); mret_in = 0;
    chk("mret_wins_pc", redirect_pc_out, 32'h100);
    tick();
    flush_done_in = 1; tick(); flush_done_in = 0;
    tick();
    chk("irq_after_mret", redirect_valid_out, 1);
    chk("irq_after_mret_pc", redirect_pc_out, 32'h22C);
    irq_meip_in = 0;
    drain();

    // Counter carry and write priority.
    csr_op(12'hB80, 2'b01, 1'b1, 32'h0);
    csr_op(12'hB00, 2'b01, 1'b1, 32'hFFFFFFFF);
    csr_op(12'hB80, 2'b10, 1'b0, 0); chk("cyc_hi_before", last_rd, 0);
    csr_op(12'hB00, 2'b10, 1'b0, 0); chk("cyc_lo_wrap", last_rd, 0);
    csr_op(12'hB80, 2'b10, 1'b0, 0); chk("cyc_hi_carry", last_rd, 1);
    csr_op(12'hB00, 2'b01, 1'b1, 32'h50);
    csr_op(12'hB00, 2'b10, 1'b0, 0); chk("cyc_write_wins", last_rd, 32'h50);

    // Stall with an interrupt pending, then reset during flush wait.
    csr_op(12'h300, 2'b10, 1'b1, 32'h8);
    rdy_in = 0; irq_meip_in = 1;
    for (int k = 0; k < 5; k++) begin
      csr_op(12'hB00, 2'b10, 1'b0, 0);
      chk("stall_no_redirect", redirect_valid_out, 0);
    end
    rdy_in = 1;
    tick();
    chk("post_stall_irq", redirect_valid_out, 1);
    tick();
    tick();
    chk("in_flush_wait", csr_ready_out, 0);
    do_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      csr_req_in    = (m_phase == 0) && ($urandom_range(0, 1) == 1);
      csr_addr_in   = addrs[$urandom_range(0, 25)];
      csr_op_in     = 2'($urandom_range(1, 3));
      csr_wen_in    = ($urandom_range(0, 3) != 0);
      csr_wdata_in  = ($urandom_range(0, 1) == 1) ? $urandom : (32'h888 | 32'($urandom_range(0, 3)));
      retire_in     = ($urandom_range(0, 1) == 1);
      epc_in        = $urandom;
      mret_in       = (m_phase == 0) && ($urandom_range(0, 19) == 0);
      irq_mtip_in   = ($urandom_range(0, 3) == 0);
      irq_msip_in   = ($urandom_range(0, 3) == 0);
      irq_meip_in   = ($urandom_range(0, 3) == 0);
      flush_done_in = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
